// File: rtl/vc_pack_pkg.sv
// Shared types and helpers for the FIFO pop packer: the packer FSM states
// and the bit offset of a lane within a packed word.
package vc_pack_pkg;

    typedef enum logic [0:0] {
        PACK_ACC   = 1'b0,
        PACK_FLUSH = 1'b1
    } pack_state_e;

    function automatic int lane_lsb(input int lane, input int data_width);
        return lane * data_width;
    endfunction

endpackage

// File: rtl/pack_out_reg.sv
// Valid/ready holding register for the packed word: loads a new word,
// holds it under back-pressure and drops valid once it is accepted.
module pack_out_reg #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic [WIDTH-1:0]     i_data,
    input  logic [CNT_WIDTH-1:0] i_cnt,
    input  logic                 i_last,
    input  logic                 i_ready,
    output logic                 o_valid,
    output logic [WIDTH-1:0]     o_data,
    output logic [CNT_WIDTH-1:0] o_cnt,
    output logic                 o_last
);

    logic                 r_valid;
    logic [WIDTH-1:0]     r_data;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_last;

    // Loads only happen when the slot is free, so a load wins over an accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= {WIDTH{1'b0}};
            r_cnt   <= {CNT_WIDTH{1'b0}};
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_cnt   <= i_cnt;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_cnt   = r_cnt;
    assign o_last  = r_last;

endmodule

// File: rtl/fifo_pop_packer.sv
// Pops narrow FIFO entries and packs PACK_NUM of them into one wide word;
// a flush emits the accumulated partial word with out_last set.
module fifo_pop_packer
    import vc_pack_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int PACK_NUM   = 4,
    localparam int CNT_WIDTH  = $clog2(PACK_NUM + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           fifo_empty,
    input  logic [DATA_WIDTH-1:0]          fifo_dout,
    output logic                           fifo_rd_ena,
    input  logic                           flush,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH*PACK_NUM-1:0] out_data,
    output logic [CNT_WIDTH-1:0]           out_cnt,
    output logic                           out_last,
    output logic                           busy
);

    localparam int ACC_W = (PACK_NUM - 1) * DATA_WIDTH;
    localparam int OUT_W = PACK_NUM * DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(PACK_NUM - 1);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(PACK_NUM);

    pack_state_e          r_state;
    logic [ACC_W-1:0]     r_acc;
    logic [CNT_WIDTH-1:0] r_acc_cnt;

    logic                 w_slot_free;
    logic                 w_rd_ena;
    logic                 w_complete;
    logic                 w_flush_load;
    logic                 w_load;
    logic [OUT_W-1:0]     w_load_data;
    logic [CNT_WIDTH-1:0] w_load_cnt;
    logic                 w_load_last;

    // Pop decision and the word presented to the output register.
    always_comb begin
        w_slot_free  = !out_valid || out_ready;
        w_rd_ena     = rst_n && (r_state == PACK_ACC) && !flush && !fifo_empty &&
                       ((r_acc_cnt < LAST_IDX) || w_slot_free);
        w_complete   = w_rd_ena && (r_acc_cnt == LAST_IDX);
        w_flush_load = (r_state == PACK_FLUSH) && w_slot_free;
        w_load       = w_complete || w_flush_load;
        // Unfilled accumulator lanes are always zero, so a partial word needs no masking.
        if (w_complete) begin
            w_load_data = {fifo_dout, r_acc};
            w_load_cnt  = FULL_CNT;
            w_load_last = 1'b0;
        end else begin
            w_load_data = {{DATA_WIDTH{1'b0}}, r_acc};
            w_load_cnt  = r_acc_cnt;
            w_load_last = 1'b1;
        end
    end

    // Accumulator, lane counter and ACC/FLUSH state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= PACK_ACC;
            r_acc     <= {ACC_W{1'b0}};
            r_acc_cnt <= {CNT_WIDTH{1'b0}};
        end else begin
            case (r_state)
                PACK_ACC: begin
                    if (w_complete) begin
                        r_acc     <= {ACC_W{1'b0}};
                        r_acc_cnt <= {CNT_WIDTH{1'b0}};
                    end else if (w_rd_ena) begin
                        for (int i = 0; i < PACK_NUM - 1; i++) begin
                            if (r_acc_cnt == CNT_WIDTH'(i)) begin
                                r_acc[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] <= fifo_dout;
                            end
                        end
                        r_acc_cnt <= r_acc_cnt + CNT_WIDTH'(1);
                    end else if (flush && (r_acc_cnt != {CNT_WIDTH{1'b0}})) begin
                        r_state <= PACK_FLUSH;
                    end
                end
                PACK_FLUSH: begin
                    if (w_slot_free) begin
                        r_acc     <= {ACC_W{1'b0}};
                        r_acc_cnt <= {CNT_WIDTH{1'b0}};
                        r_state   <= PACK_ACC;
                    end
                end
                default: begin
                    r_state <= PACK_ACC;
                end
            endcase
        end
    end

    pack_out_reg #(
        .WIDTH     (OUT_W),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_data  (w_load_data),
        .i_cnt   (w_load_cnt),
        .i_last  (w_load_last),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_data  (out_data),
        .o_cnt   (out_cnt),
        .o_last  (out_last)
    );

    assign fifo_rd_ena = w_rd_ena;
    assign busy        = rst_n && ((r_acc_cnt != {CNT_WIDTH{1'b0}}) || out_valid ||
                                   (r_state == PACK_FLUSH));

endmodule

// File: tb/tb_fifo_pop_packer.sv
// Scoreboard bench for fifo_pop_packer: a queue-based FIFO and lane model
// predict pops and packed words; a monitor checks them as the DUT presents them.
module tb_fifo_pop_packer;

    localparam int DW = 8;
    localparam int PN = 4;
    localparam int CW = $clog2(PN + 1);
    localparam int OW = DW * PN;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          fifo_rd_ena;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic [CW-1:0] out_cnt;
    logic          out_last;
    logic          busy;

    typedef struct packed {
        logic [OW-1:0] data;
        logic [CW-1:0] cnt;
        logic          last;
    } word_t;

    word_t         exp_q[$];
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] m_lanes[$];
    bit            m_full;
    bit            m_flush_pend;
    bit            chk_en;
    bit            done;
    bit            probe_zero;
    bit            exp_rd_v;
    bit            exp_busy_v;
    bit            exp_valid_v;
    int            checks;
    int            errors;

    fifo_pop_packer #(.DATA_WIDTH(DW), .PACK_NUM(PN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fifo_empty  (fifo_empty),
        .fifo_dout   (fifo_dout),
        .fifo_rd_ena (fifo_rd_ena),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_cnt     (out_cnt),
        .out_last    (out_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic word_t make_word(input bit last);
        word_t w;
        w.data = '0;
        for (int i = 0; i < m_lanes.size(); i++) begin
            w.data = w.data | (OW'(m_lanes[i]) << (DW * i));
        end
        w.cnt  = CW'(m_lanes.size());
        w.last = last;
        return w;
    endfunction

    // One clock cycle: drive inputs, predict pop/busy/valid, update the model at the edge.
    task automatic cyc(input bit f, input bit r);
        bit            dut_rd;
        bit            slot_free_m;
        bit            new_full;
        logic [DW-1:0] head;
        flush       = f;
        out_ready   = r;
        fifo_empty  = (fifo_q.size() == 0);
        fifo_dout   = fifo_empty ? 8'h00 : fifo_q[0];
        head        = fifo_dout;
        slot_free_m = !m_full || r;
        exp_rd_v    = rst_n && !f && !m_flush_pend && !fifo_empty &&
                      ((m_lanes.size() < PN - 1) || slot_free_m);
        exp_busy_v  = rst_n && ((m_lanes.size() > 0) || m_full || m_flush_pend);
        exp_valid_v = m_full;
        #1;
        dut_rd = fifo_rd_ena;
        @(posedge clk);
        if (dut_rd && (fifo_q.size() > 0)) void'(fifo_q.pop_front());
        if (!rst_n) begin
            if (m_full) void'(exp_q.pop_back());
            m_lanes.delete();
            m_full       = 1'b0;
            m_flush_pend = 1'b0;
            chk_en       = 1'b1;
        end else begin
            new_full = m_full && !r;
            if (!m_flush_pend && exp_rd_v) begin
                m_lanes.push_back(head);
                if (m_lanes.size() == PN) begin
                    exp_q.push_back(make_word(1'b0));
                    m_lanes.delete();
                    new_full = 1'b1;
                end
            end else if (m_flush_pend && slot_free_m) begin
                exp_q.push_back(make_word(1'b1));
                m_lanes.delete();
                m_flush_pend = 1'b0;
                new_full     = 1'b1;
            end else if (f && (m_lanes.size() > 0)) begin
                m_flush_pend = 1'b1;
            end
            m_full = new_full;
        end
        @(negedge clk);
    endtask

    task automatic push(input logic [DW-1:0] v);
        fifo_q.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: compares per-cycle predictions and pops the scoreboard on each accepted word.
    always begin
        word_t w;
        @(negedge clk);
        #3;
        if (chk_en) begin
            check("fifo_rd_ena", 64'(fifo_rd_ena), 64'(exp_rd_v));
            check("out_valid", 64'(out_valid), 64'(exp_valid_v));
            check("busy", 64'(busy), 64'(exp_busy_v));
        end
        if (probe_zero) begin
            check("reset_out_data", 64'(out_data), 64'(0));
            check("reset_out_cnt", 64'(out_cnt), 64'(0));
            check("reset_out_last", 64'(out_last), 64'(0));
        end
        if (chk_en && rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_word actual=0x%0h required=no_word", out_data);
            end else begin
                w = exp_q.pop_front();
                check("out_data", 64'(out_data), 64'(w.data));
                check("out_cnt", 64'(out_cnt), 64'(w.cnt));
                check("out_last", 64'(out_last), 64'(w.last));
            end
        end
        if (done) begin
            check("words_left", 64'(exp_q.size()), 64'(0));
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout  = 8'h00;
        @(negedge clk);

        // Reset with a non-empty FIFO, then one full word.
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        cyc(1'b0, 1'b1);
        probe_zero = 1'b1;
        cyc(1'b0, 1'b1);
        probe_zero = 1'b0;
        rst_n = 1'b1;
        repeat (6) cyc(1'b0, 1'b1);

        // Back-pressure: second word completes on the same edge as the accept.
        for (int i = 1; i <= 8; i++) push(DW'(i));
        repeat (10) cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        repeat (2) cyc(1'b0, 1'b0);
        repeat (2) cyc(1'b0, 1'b1);

        // Partial flush of two lanes.
        push(8'hA1); push(8'hA2);
        repeat (3) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b1);

        // Flush with nothing accumulated, then flush suppressing one pop.
        cyc(1'b1, 1'b1);
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        cyc(1'b1, 1'b1);
        repeat (6) cyc(1'b0, 1'b1);

        // Reset with three lanes accumulated.
        push(8'h10); push(8'h20); push(8'h30);
        repeat (3) cyc(1'b0, 1'b1);
        rst_n = 1'b0;
        cyc(1'b0, 1'b1);
        rst_n = 1'b1;
        push(8'h40); push(8'h50); push(8'h60); push(8'h70);
        repeat (6) cyc(1'b0, 1'b1);

        // Random traffic with occasional flush, stall and reset.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(1, 0) == 1) push(DW'($urandom_range(255, 0)));
            rst_n = ($urandom_range(249, 0) != 0);
            cyc($urandom_range(9, 0) == 0, $urandom_range(2, 0) != 0);
        end
        rst_n = 1'b1;

        // Drain the FIFO, flush the tail and let the last word go.
        for (int n = 0; (n < 400) && (fifo_q.size() > 0); n++) cyc(1'b0, 1'b1);
        repeat (4) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        repeat (6) cyc(1'b0, 1'b1);

        done = 1'b1;
        repeat (4) @(posedge clk);
        $display("FAIL monitor_stalled actual=no_summary required=summary");
        $fatal(1, "monitor did not finish");
    end

endmodule

// File: doc/fifo_pop_packer.md
Name: fifo_pop_packer

Overview:
Reader-side controller for the common synchronous FIFO. It pops narrow entries from the FIFO's read port and packs PACK_NUM consecutive entries into one wide word. The wide word is presented on a valid/ready output interface. A flush input emits a partial word so the tail of a stream is never stranded, e.g. at the end of a vector-cache line transfer.

Parameters:
DATA_WIDTH, 8, width of one FIFO entry (one lane)
PACK_NUM, 4, lanes per output word; must be >= 2
CNT_WIDTH, $clog2(PACK_NUM+1), localparam; width of the lane counters

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
fifo_empty  input  1  FIFO empty flag
fifo_dout  input  DATA_WIDTH  FIFO head entry; valid in the same cycle whenever fifo_empty=0
fifo_rd_ena  output  1  pop request; the head is consumed at the clock edge where fifo_rd_ena=1
flush  input  1  request to emit the accumulated partial word
out_valid  output  1  wide word valid
out_ready  input  1  downstream accept
out_data  output  DATA_WIDTH*PACK_NUM  packed word; lane 0 (first popped) in the LSBs
out_cnt  output  CNT_WIDTH  number of valid lanes in out_data (1..PACK_NUM)
out_last  output  1  word was produced by a flush
busy  output  1  acc_cnt!=0 or out_valid or FSM in FLUSH

Behaviour:
- Reset: synchronous, active-low; clk and rst_n only.
  - Reset values: out_valid=0, out_data=0, out_cnt=0, out_last=0, acc=0, acc_cnt=0, FSM=ACC.
  - fifo_rd_ena and busy evaluate to 0 during and after reset until the FIFO is non-empty.
- Internal state: accumulator acc (PACK_NUM-1 lanes), acc_cnt (0..PACK_NUM-1), output register, 2-state FSM {ACC, FLUSH}.
- slot_free = !out_valid || out_ready.
- fifo_rd_ena is combinational: FSM==ACC && !flush && !fifo_empty && (acc_cnt<PACK_NUM-1 || slot_free).
- Pop with acc_cnt<PACK_NUM-1: fifo_dout is written to lane acc_cnt; acc_cnt increments.
- Pop with acc_cnt==PACK_NUM-1 (completing pop):
  - At the same edge the output register loads {fifo_dout, acc lanes}, out_cnt=PACK_NUM, out_last=0, out_valid=1.
  - acc_cnt returns to 0 and acc clears.
- Latency: out_valid rises the cycle after the completing pop.
- Throughput: with out_ready held at 1, one pop per cycle and one wide word every PACK_NUM cycles, no bubbles.
- Output hold: while out_valid && !out_ready, out_data, out_cnt and out_last are stable.
- Handshake: the transfer occurs at the edge where out_valid && out_ready. out_valid falls next cycle unless a new word loads at that same edge (back-to-back allowed).
- Flush:
  - Any cycle with flush=1 forces fifo_rd_ena=0 for that cycle.
  - If FSM==ACC, flush=1 and acc_cnt>0: go to FLUSH.
  - If FSM==ACC, flush=1 and acc_cnt==0: ignored, no output produced.
- FLUSH state:
  - No pops.
  - When slot_free: load the output register with the acc lanes, unused upper lanes zero, out_cnt=acc_cnt, out_last=1, out_valid=1.
  - Clear acc and acc_cnt, return to ACC.
  - flush asserted again while in FLUSH has no additional effect.
- FIFO empty mid-word: the partial word is retained indefinitely, with no timeout.
- Reset mid-operation: the partial accumulator and any pending output word are discarded. FIFO contents are not affected by this block.

Decomposition:
- Shared package vc_pack_pkg:
  - FSM enum pack_state_e {PACK_ACC, PACK_FLUSH}.
  - Lane-index helper function lane_lsb(i) = i*DATA_WIDTH.
- One sub-module is natural: pack_out_reg. It is the output valid/ready holding register with load, hold and accept, parameterised by width.
- Accumulator, counter and FSM stay in the top.

Test Plan (DATA_WIDTH=8, PACK_NUM=4):
- Reset: rst_n=0 for 2 cycles with FIFO non-empty -> out_valid=0, out_data=0, fifo_rd_ena=0, busy=0.
- FIFO holds 0x11,0x22,0x33,0x44; out_ready=1 -> fifo_rd_ena=1 for 4 consecutive cycles; the next cycle shows out_valid=1, out_data=0x44332211, out_cnt=4, out_last=0.
- Back-pressure:
  - Stimulus: 8 entries 0x01..0x08, out_ready=0.
  - Response: out_data=0x04030201 held; 3 further pops, then fifo_rd_ena=0 with acc_cnt=3.
  - Raise out_ready for 1 cycle: the 8th pop and the accept happen at the same edge; next cycle out_data=0x08070605, out_valid=1.
- Partial flush:
  - Stimulus: pop 0xA1,0xA2, FIFO empty, 1-cycle flush pulse.
  - Response: fifo_rd_ena=0 during the flush cycle; then out_data=0x0000A2A1, out_cnt=2, out_last=1; busy=0 after accept.
- Empty flush: flush pulse with acc_cnt=0 and FIFO empty -> no out_valid, busy stays 0. A flush pulse with FIFO non-empty suppresses exactly that cycle's pop.
- Mid-op reset:
  - Stimulus: 3 pops (0x10,0x20,0x30), then rst_n=0 for 1 cycle; FIFO then supplies 0x40..0x70.
  - Response: out_data=0x70605040, no stale lanes.
